ahb_key_event_ctrl: RTL and testbench

AHB-Lite slave for NUM_KEYS push-buttons, the parametrised successor to the single-shot key peripheral.
- Each key is synchronised and debounced.
- Press and (optional) release edges are packed into event words and queued in a FIFO, so no event is lost while firmware is busy.
- Provides a maskable level interrupt, an overflow flag and a raw-state register.
- Never stalls the bus (HREADYOUT tied high); sits on the AHB-Lite decoder/mux beside the other peripherals.

---
 rtl/ahb_key_pkg.sv | 23 ++
 rtl/ahb_key_event_ctrl_debounce.sv | 43 ++++
 rtl/ahb_key_event_ctrl.sv | 141 ++++++++++++++
 tb/tb_ahb_key_event_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_key_pkg.sv
// Shared register map and bit positions for the AHB key event controller.
package ahb_key_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RAW    = 2'd3
  } reg_addr_e;

  localparam int unsigned STAT_CNT_W = 8;
  localparam int unsigned STAT_EMPTY = 8;
  localparam int unsigned STAT_FULL  = 9;
  localparam int unsigned STAT_OVF   = 10;

  localparam int unsigned CTRL_W          = 3;
  localparam int unsigned CTRL_IRQ_EN     = 0;
  localparam int unsigned CTRL_REL_EN     = 1;
  localparam int unsigned CTRL_OVF_IRQ_EN = 2;

  localparam int unsigned REL_BASE = 16;

endpackage

// File: rtl/ahb_key_event_ctrl_debounce.sv
// Per-key two-flop synchroniser followed by a stable-count debouncer.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ahb_key_event_ctrl.sv
// AHB-Lite key peripheral: debounced keys, press/release event FIFO, maskable IRQ.
module ahb_key_event_ctrl
  import ahb_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic                HREADY,
  input  logic [31:0]         HWDATA,
  output logic                HREADYOUT,
  output logic [31:0]         HRDATA,
  output logic                KEY_IRQ,
  input  logic [NUM_KEYS-1:0] KEY
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NUM_KEYS-1:0] deb, deb_prev_q, press, rel;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i   (HCLK),
      .rst_i   (HRESET),
      .key_i   (KEY[g]),
      .level_o (deb[g])
    );
  end

  logic        sel_q, wr_q, tr_q;
  reg_addr_e   addr_q;
  logic        rd_en, wr_en;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d, irq_q, irq_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       ev;
  logic              empty, full, push_req, push, pop, ovf_set;

  assign HREADYOUT = 1'b1;
  assign KEY_IRQ   = irq_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q  <= 1'b0;
      wr_q   <= 1'b0;
      tr_q   <= 1'b0;
      addr_q <= REG_DATA;
    end else if (HREADY) begin
      sel_q  <= HSEL;
      wr_q   <= HWRITE;
      tr_q   <= HTRANS[1];
      addr_q <= reg_addr_e'(HADDR[3:2]);
    end
  end

  assign rd_en = sel_q & tr_q & ~wr_q;
  assign wr_en = sel_q & tr_q & wr_q;

  assign press = deb & ~deb_prev_q;
  assign rel   = ~deb & deb_prev_q & {NUM_KEYS{ctrl_q[CTRL_REL_EN]}};

  always_comb begin
    ev                         = '0;
    ev[NUM_KEYS-1:0]           = press;
    ev[REL_BASE +: NUM_KEYS]   = rel;
  end

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign push_req = |{press, rel};
  assign pop      = rd_en & (addr_q == REG_DATA) & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  always_comb begin
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    if (wr_en && addr_q == REG_CTRL) ctrl_d = HWDATA[CTRL_W-1:0];
    if (wr_en && addr_q == REG_STATUS && HWDATA[STAT_OVF]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    irq_d = (ctrl_d[CTRL_IRQ_EN] & (cnt_d != '0)) | (ctrl_d[CTRL_OVF_IRQ_EN] & ovf_d);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      deb_prev_q <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ctrl_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_prev_q <= deb;
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wp_q] <= ev;
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (addr_q)
        REG_DATA:   if (!empty) HRDATA = mem_q[rp_q];
        REG_STATUS: begin
          HRDATA[STAT_CNT_W-1:0] = STAT_CNT_W'(cnt_q);
          HRDATA[STAT_EMPTY]     = empty;
          HRDATA[STAT_FULL]      = full;
          HRDATA[STAT_OVF]       = ovf_q;
        end
        REG_CTRL:   HRDATA[CTRL_W-1:0]   = ctrl_q;
        REG_RAW:    HRDATA[NUM_KEYS-1:0] = deb;
        default:    HRDATA = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:11], HWDATA[9:3]};

endmodule

// File: tb/tb_ahb_key_event_ctrl.sv
// Randomised and directed bench for ahb_key_event_ctrl against a behavioural model.
module tb_ahb_key_event_ctrl;

  localparam int NK = 5;
  localparam int DC = 16;
  localparam int FD = 4;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic          HREADYOUT, KEY_IRQ;
  logic [31:0]   HRDATA;
  logic [NK-1:0] KEY;

  ahb_key_event_ctrl #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DC),
    .FIFO_DEPTH      (FD)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .KEY_IRQ   (KEY_IRQ),
    .KEY       (KEY)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: key histories, stable-run counts, event queue.
  logic [NK-1:0] h0, h1, lvl, plvl;
  int            streak [NK];
  logic [31:0]   fifo [$];
  bit            m_ovf, m_irq;
  logic [2:0]    m_ctrl;
  bit            d_sel, d_wr, d_tr;
  logic [1:0]    d_addr;

  function automatic void model_reset();
    h0 = '0; h1 = '0; lvl = '0; plvl = '0;
    foreach (streak[k]) streak[k] = 0;
    fifo.delete();
    m_ovf = 0; m_irq = 0; m_ctrl = '0;
    d_sel = 0; d_wr = 0; d_tr = 0; d_addr = '0;
  endfunction

  function automatic void model_step();
    logic [NK-1:0] p, r;
    logic [31:0]   ev;
    bit rd, wr, pop, ovf_set, was_full;
    if (HRESET) begin
      model_reset();
      return;
    end
    rd = d_sel && d_tr && !d_wr;
    wr = d_sel && d_tr && d_wr;
    p  = lvl & ~plvl;
    r  = m_ctrl[1] ? (~lvl & plvl) : '0;
    ev = 32'(p) | (32'(r) << 16);
    was_full = (fifo.size() == FD);
    pop = rd && d_addr == 2'd0 && fifo.size() > 0;
    ovf_set = 0;
    if (pop) void'(fifo.pop_front());
    if ((p | r) != 0) begin
      if (was_full && !pop) ovf_set = 1;
      else fifo.push_back(ev);
    end
    if (wr && d_addr == 2'd1 && HWDATA[10]) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
    if (wr && d_addr == 2'd2) m_ctrl = HWDATA[2:0];
    m_irq = (m_ctrl[0] && fifo.size() > 0) || (m_ctrl[2] && m_ovf);
    plvl = lvl;
    for (int k = 0; k < NK; k++) begin
      if (h1[k] != lvl[k]) begin
        streak[k]++;
        if (streak[k] == DC) begin
          lvl[k] = ~lvl[k];
          streak[k] = 0;
        end
      end else begin
        streak[k] = 0;
      end
    end
    h1 = h0;
    h0 = KEY;
    if (HREADY) begin
      d_sel = HSEL; d_wr = HWRITE; d_tr = HTRANS[1]; d_addr = HADDR[3:2];
    end
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] v;
    v = '0;
    if (d_sel && d_tr && !d_wr) begin
      case (d_addr)
        2'd0: v = (fifo.size() > 0) ? fifo[0] : 32'h0;
        2'd1: v = {21'b0, m_ovf, fifo.size() == FD, fifo.size() == 0, 8'(fifo.size())};
        2'd2: v = {29'b0, m_ctrl};
        default: v = 32'(lvl);
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
    check_eq("hrdata", HRDATA, exp_rdata());
    check_eq("irq", 32'(KEY_IRQ), 32'(m_irq));
    check_eq("hreadyout", 32'(HREADYOUT), 32'h1);
  endtask

  task automatic bus_idle();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = '0; HREADY = 1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
    tick();
    bus_idle();
    d = HRDATA;
    tick();
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
    tick();
    bus_idle();
    HWDATA = d;
    tick();
    HWDATA = '0;
  endtask

  task automatic press_release(input int k, input int hold);
    KEY = NK'(1 << k);
    repeat (hold) tick();
    KEY = '0;
    repeat (hold) tick();
  endtask

  initial begin
    logic [31:0] d;
    HRESET = 1; HWDATA = '0; KEY = '0;
    bus_idle();
    model_reset();
    repeat (3) tick();
    HRESET = 0;
    tick();

    ahb_read(32'h0, d); check_eq("rst_data", d, 32'h0);
    ahb_read(32'h4, d); check_eq("rst_status", d, 32'h100);
    ahb_read(32'h8, d); check_eq("rst_ctrl", d, 32'h0);
    ahb_read(32'hC, d); check_eq("rst_raw", d, 32'h0);

    ahb_write(32'h8, 32'h1);
    KEY = 5'b00100;
    repeat (18) tick();
    check_eq("lat_irq_lo", 32'(KEY_IRQ), 32'h0);
    tick();
    check_eq("lat_irq_hi", 32'(KEY_IRQ), 32'h1);
    repeat (11) tick();
    ahb_read(32'h4, d); check_eq("one_status", d, 32'h001);
    ahb_read(32'h0, d); check_eq("one_data", d, 32'h4);
    ahb_read(32'h4, d); check_eq("one_empty", d, 32'h100);
    check_eq("one_irq_off", 32'(KEY_IRQ), 32'h0);

    KEY = '0;
    repeat (40) tick();
    KEY = 5'b00001;
    repeat (10) tick();
    KEY = '0;
    repeat (40) tick();
    ahb_read(32'hC, d); check_eq("glitch_raw", d, 32'h0);
    ahb_read(32'h4, d); check_eq("glitch_status", d, 32'h100);

    ahb_write(32'h8, 32'h2);
    KEY = 5'b00011;
    repeat (40) tick();
    KEY = '0;
    repeat (40) tick();
    ahb_read(32'h0, d); check_eq("rel_press", d, 32'h3);
    ahb_read(32'h0, d); check_eq("rel_release", d, 32'h30000);
    ahb_read(32'h4, d); check_eq("rel_empty", d, 32'h100);

    ahb_write(32'h8, 32'h0);
    for (int i = 0; i < 5; i++) press_release(i, 25);
    ahb_read(32'h4, d); check_eq("ovf_status", d, 32'h604);
    ahb_write(32'h4, 32'h400);
    ahb_read(32'h4, d); check_eq("ovf_cleared", d, 32'h204);
    for (int i = 0; i < 4; i++) begin
      ahb_read(32'h0, d); check_eq("ovf_order", d, 32'(1 << i));
    end

    for (int i = 0; i < 4; i++) press_release(i, 25);
    KEY = 5'h10;
    repeat (17) tick();
    ahb_read(32'h0, d); check_eq("fullpp_head", d, 32'h1);
    ahb_read(32'h4, d); check_eq("fullpp_status", d, 32'h204);
    for (int i = 1; i < 5; i++) begin
      ahb_read(32'h0, d); check_eq("fullpp_order", d, 32'(1 << i));
    end
    KEY = '0;
    repeat (25) tick();

    press_release(1, 25);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h0;
    tick();
    bus_idle();
    HRESET = 1;
    tick();
    HRESET = 0;
    tick();
    ahb_read(32'h4, d); check_eq("midrst_status", d, 32'h100);
    ahb_read(32'h0, d); check_eq("midrst_data", d, 32'h0);

    for (int it = 0; it < 300; it++) begin
      int unsigned op;
      op = $urandom_range(0, 6);
      if ($urandom_range(0, 2) == 0) KEY = NK'($urandom);
      case (op)
        0, 1: repeat ($urandom_range(1, 25)) tick();
        2: ahb_read({28'b0, 2'($urandom), 2'b00}, d);
        3: ahb_read(32'h0, d);
        4: ahb_write({28'b0, 2'($urandom), 2'b00}, $urandom);
        5: ahb_write(32'h8, 32'($urandom_range(0, 7)));
        default: begin
          HREADY = 0; HSEL = 1; HTRANS = 2'b10; HWRITE = 1'($urandom);
          HADDR = {28'b0, 2'($urandom), 2'b00}; HWDATA = $urandom;
          tick();
          bus_idle();
          HWDATA = '0;
          tick();
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
